tmr_voted_counter: RTL and testbench

TMR_VOTED_COUNTER -- requirements
Module: tmr_voted_counter

---
 rtl/tmr_pkg.sv | 21 ++
 rtl/majority_voter_w.sv | 13 +
 rtl/tmr_voted_counter.sv | 101 ++++++++++
 tb/tb_tmr_voted_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-redundant voted counter.
package tmr_pkg;

    typedef enum logic [1:0] {
        INJ_NONE = 2'd0,
        INJ_A    = 2'd1,
        INJ_B    = 2'd2,
        INJ_C    = 2'd3
    } inj_sel_e;

    // Fault-injection code that targets redundant copy idx (0=A, 1=B, 2=C).
    function automatic inj_sel_e copy_inj_code(input int idx);
        case (idx)
            0:       return INJ_A;
            1:       return INJ_B;
            2:       return INJ_C;
            default: return INJ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/majority_voter_w.sv
// Bitwise two-out-of-three majority vote over three WIDTH-bit words.
module majority_voter_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_voted_counter.sv
// Counter held in three redundant copies, read through a bitwise majority vote,
// with per-copy fault injection, disagreement flags and a saturating error count.
module tmr_voted_counter
    import tmr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ERRCNT_W = 4,
    parameter int SCRUB    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [1:0]          inj_sel,
    input  logic [WIDTH-1:0]    inj_mask,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    cnt,
    output logic                tc,
    output logic                err,
    output logic                multi_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    (* keep *) logic [WIDTH-1:0] vote;
    logic [ERRCNT_W-1:0] err_cnt_reg;
    logic [ERRCNT_W-1:0] err_cnt_next;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_copy
            (* keep *) logic [WIDTH-1:0] copy_reg;
            logic [WIDTH-1:0] base_next;
            logic [WIDTH-1:0] copy_next;

            // Increments always start from the vote so one bad copy cannot skew the count.
            always_comb begin
                base_next = copy_reg;
                if (load) begin
                    base_next = load_val;
                end else if (en) begin
                    base_next = vote + WIDTH'(1);
                end else if (SCRUB != 0) begin
                    base_next = vote;
                end
                copy_next = base_next;
                if (inj_sel == copy_inj_code(gi)) begin
                    copy_next = base_next ^ inj_mask;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    copy_reg <= '0;
                end else begin
                    copy_reg <= copy_next;
                end
            end
        end
    endgenerate

    majority_voter_w #(
        .WIDTH(WIDTH)
    ) u_voter (
        .a(g_copy[0].copy_reg),
        .b(g_copy[1].copy_reg),
        .c(g_copy[2].copy_reg),
        .y(vote)
    );

    assign cnt = vote;
    assign tc  = en & ~load & ~rst & (vote == {WIDTH{1'b1}});

    assign err = (g_copy[0].copy_reg != g_copy[1].copy_reg)
               | (g_copy[1].copy_reg != g_copy[2].copy_reg)
               | (g_copy[0].copy_reg != g_copy[2].copy_reg);

    assign multi_err = (g_copy[0].copy_reg != g_copy[1].copy_reg)
                     & (g_copy[1].copy_reg != g_copy[2].copy_reg)
                     & (g_copy[0].copy_reg != g_copy[2].copy_reg);

    // Clear wins over a simultaneous error; the count sticks at all-ones.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr) begin
            err_cnt_next = '0;
        end else if (err && (err_cnt_reg != {ERRCNT_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_tmr_voted_counter.sv
// Self-checking bench: a scrubbing (SCRUB=1) and a holding (SCRUB=0) counter driven in parallel.
module tb_tmr_voted_counter;

    logic       clk = 1'b0;
    logic       rst, en, load, err_clr;
    logic [7:0] load_val, inj_mask;
    logic [1:0] inj_sel;

    logic [7:0] cnt_s, cnt_h;
    logic       tc_s, tc_h, err_s, err_h, me_s, me_h;
    logic [3:0] ec_s, ec_h;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: [0] = scrubbing device, [1] = holding device.
    int m_copy [2][3];
    int m_ec   [2];

    always #5 clk = ~clk;

    tmr_voted_counter #(.WIDTH(8), .ERRCNT_W(4), .SCRUB(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr),
        .cnt(cnt_s), .tc(tc_s), .err(err_s), .multi_err(me_s), .err_cnt(ec_s)
    );

    tmr_voted_counter #(.WIDTH(8), .ERRCNT_W(4), .SCRUB(0)) dut_h (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr),
        .cnt(cnt_h), .tc(tc_h), .err(err_h), .multi_err(me_h), .err_cnt(ec_h)
    );

    // A bit of the vote is set when at least two copies have it set.
    function automatic int m_vote(input int d);
        int r = 0;
        for (int b = 0; b < 8; b++) begin
            int ones = 0;
            for (int k = 0; k < 3; k++) ones += (m_copy[d][k] >> b) & 1;
            if (ones >= 2) r += (1 << b);
        end
        return r;
    endfunction

    function automatic bit m_err(input int d);
        return !(m_copy[d][0] == m_copy[d][1] && m_copy[d][1] == m_copy[d][2]);
    endfunction

    function automatic bit m_multi(input int d);
        return m_copy[d][0] != m_copy[d][1] && m_copy[d][1] != m_copy[d][2]
            && m_copy[d][0] != m_copy[d][2];
    endfunction

    function automatic bit m_tc(input int d);
        return en && !load && !rst && m_vote(d) == 255;
    endfunction

    // Advance one clock edge and move the reference model along with it.
    task automatic step();
        int nxt [2][3];
        int nec [2];
        for (int d = 0; d < 2; d++) begin
            int v = m_vote(d);
            for (int k = 0; k < 3; k++) begin
                int base;
                if (load)        base = int'(load_val);
                else if (en)     base = (v + 1) % 256;
                else if (d == 0) base = v;
                else             base = m_copy[d][k];
                if (inj_sel == 2'(k + 1)) base = base ^ int'(inj_mask);
                nxt[d][k] = rst ? 0 : base;
            end
            if (rst || err_clr)                nec[d] = 0;
            else if (m_err(d) && m_ec[d] < 15) nec[d] = m_ec[d] + 1;
            else                               nec[d] = m_ec[d];
        end
        $display("cyc %0d rst=%b en=%b load=%b lv=%h inj=%0d mask=%h clr=%b | cnt_s=%h err_s=%b ec_s=%0d cnt_h=%h err_h=%b me_h=%b ec_h=%0d",
                 cyc, rst, en, load, load_val, inj_sel, inj_mask, err_clr,
                 cnt_s, err_s, ec_s, cnt_h, err_h, me_h, ec_h);
        @(posedge clk);
        m_copy = nxt;
        m_ec   = nec;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b0; load = 1'b0; err_clr = 1'b0;
        load_val = 8'h00; inj_sel = 2'd0; inj_mask = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'hA5;
        inj_sel = 2'd3; inj_mask = 8'hFF; err_clr = 1'b0;
        step();
        checks++;
        if (cnt_s !== 8'h00 || cnt_h !== 8'h00) begin
            errors++; $display("FAIL reset_cnt: got %h/%h want 00", cnt_s, cnt_h);
        end
        checks++;
        if ({err_s, err_h, me_s, me_h, tc_s, tc_h} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {err_s, err_h, me_s, me_h, tc_s, tc_h});
        end
        checks++;
        if (ec_s !== 4'd0 || ec_h !== 4'd0) begin
            errors++; $display("FAIL reset_errcnt: got %0d/%0d want 0", ec_s, ec_h);
        end
        idle_inputs();
    endtask

    task automatic test_count_wrap();
        rst = 1'b1; step(); rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] exp_cnt;
            exp_cnt = 8'(i % 256);
            checks++;
            if (cnt_s !== exp_cnt || cnt_h !== exp_cnt) begin
                errors++; $display("FAIL count_cnt: i=%0d got %h/%h want %h", i, cnt_s, cnt_h, exp_cnt);
            end
            checks++;
            if (tc_s !== (exp_cnt == 8'hFF) || tc_h !== (exp_cnt == 8'hFF)) begin
                errors++; $display("FAIL count_tc: i=%0d got %b/%b want %b", i, tc_s, tc_h, exp_cnt == 8'hFF);
            end
            checks++;
            if (err_s !== 1'b0 || err_h !== 1'b0) begin
                errors++; $display("FAIL count_err: i=%0d got %b/%b want 0", i, err_s, err_h);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_single_inject();
        load = 1'b1; load_val = 8'h10; err_clr = 1'b1; step();
        idle_inputs();
        inj_sel = 2'd2; inj_mask = 8'h01; step();
        idle_inputs();
        checks++;
        if (err_s !== 1'b1 || cnt_s !== 8'h10 || err_h !== 1'b1 || cnt_h !== 8'h10 || me_h !== 1'b0) begin
            errors++; $display("FAIL inject_seen: got err %b/%b cnt %h/%h me_h %b want 1/1 10/10 0",
                               err_s, err_h, cnt_s, cnt_h, me_h);
        end
        step();
        checks++;
        if (err_s !== 1'b0 || ec_s !== 4'd1) begin
            errors++; $display("FAIL scrub_fix: got err=%b ec=%0d want err=0 ec=1", err_s, ec_s);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (err_h !== 1'b1 || cnt_h !== 8'h10 || ec_h !== 4'd15) begin
            errors++; $display("FAIL hold_persist: got err=%b cnt=%h ec=%0d want 1 10 15", err_h, cnt_h, ec_h);
        end
        checks++;
        if (ec_s !== 4'd1) begin
            errors++; $display("FAIL scrub_ec_stable: got %0d want 1", ec_s);
        end
        load = 1'b1; load_val = 8'h10; step();
        idle_inputs();
        checks++;
        if (err_h !== 1'b0 || cnt_h !== 8'h10 || ec_h !== 4'd15) begin
            errors++; $display("FAIL hold_reload: got err=%b cnt=%h ec=%0d want 0 10 15", err_h, cnt_h, ec_h);
        end
    endtask

    task automatic test_multi_err();
        load = 1'b1; load_val = 8'h10; err_clr = 1'b1; step();
        idle_inputs();
        inj_sel = 2'd1; inj_mask = 8'h01; step();
        inj_sel = 2'd2; inj_mask = 8'h02; step();
        idle_inputs();
        checks++;
        if (me_h !== 1'b1 || err_h !== 1'b1 || cnt_h !== 8'h10) begin
            errors++; $display("FAIL hold_multi: got me=%b err=%b cnt=%h want 1 1 10", me_h, err_h, cnt_h);
        end
        checks++;
        if (me_s !== 1'b0 || err_s !== 1'b1 || cnt_s !== 8'h10) begin
            errors++; $display("FAIL scrub_multi: got me=%b err=%b cnt=%h want 0 1 10", me_s, err_s, cnt_s);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 8'hFF; step();
        load = 1'b1; en = 1'b1; load_val = 8'hFE; inj_sel = 2'd1; inj_mask = 8'h04;
        checks++;
        if (tc_s !== 1'b0 || tc_h !== 1'b0) begin
            errors++; $display("FAIL load_tc: got %b/%b want 0", tc_s, tc_h);
        end
        step();
        idle_inputs();
        checks++;
        if (cnt_s !== 8'hFE || cnt_h !== 8'hFE || err_s !== 1'b1) begin
            errors++; $display("FAIL load_over_en: got cnt %h/%h err %b want FE/FE 1", cnt_s, cnt_h, err_s);
        end
        err_clr = 1'b1; step();
        checks++;
        if (ec_s !== 4'd0 || ec_h !== 4'd0) begin
            errors++; $display("FAIL clr_wins: got %0d/%0d want 0", ec_s, ec_h);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = 1'($urandom_range(0, 1));
            load_val = 8'($urandom);
            inj_sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            inj_mask = 8'($urandom);
            err_clr  = ($urandom_range(0, 15) == 0);
            for (int d = 0; d < 2; d++) begin
                logic [7:0] g_cnt;
                logic [3:0] g_ec;
                logic       g_tc, g_err, g_me;
                g_cnt = d ? cnt_h : cnt_s;
                g_ec  = d ? ec_h  : ec_s;
                g_tc  = d ? tc_h  : tc_s;
                g_err = d ? err_h : err_s;
                g_me  = d ? me_h  : me_s;
                checks++;
                if (g_cnt !== 8'(m_vote(d)) || g_ec !== 4'(m_ec[d])) begin
                    errors++; $display("FAIL rand_state: dev=%0d i=%0d got cnt=%h ec=%0d want cnt=%h ec=%0d",
                                       d, i, g_cnt, g_ec, 8'(m_vote(d)), m_ec[d]);
                end
                checks++;
                if (g_tc !== m_tc(d) || g_err !== m_err(d) || g_me !== m_multi(d)) begin
                    errors++; $display("FAIL rand_flags: dev=%0d i=%0d got tc/err/me=%b%b%b want %b%b%b",
                                       d, i, g_tc, g_err, g_me, m_tc(d), m_err(d), m_multi(d));
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_count_wrap();
        test_single_inject();
        test_multi_err();
        test_load_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
